// File: rtl/seg7_pkg.sv
// Shared constants and types for the time-multiplexed 4-digit 7-segment driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 16-bit value onto a common-anode 4-digit display with per-frame
// snapshot, leading-zero blanking, decimal points and whole-display blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS  = 50000,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]      presc;
  logic [IDX_W-1:0]   idx;
  logic [VALUE_W-1:0] snap;
  logic               phase;
  logic [FW-1:0]      frames;
  disp_t              disp_q;

  logic               tick;
  logic               boundary;
  logic [IDX_W-1:0]   idx_nx;
  logic [VALUE_W-1:0] snap_nx;
  logic               phase_nx;
  logic [FW-1:0]      frames_nx;
  logic [NIB_W-1:0]   nibble;
  logic [SEG_W-1:0]   seg_dec;
  logic               lz_off;
  logic               suppress;
  disp_t              disp_nx;

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_c  (seg_dec)
  );

  // Everything here describes the slot that becomes visible at the coming tick edge
  always_comb begin
    tick      = (presc == PW'(DIGIT_TICKS - 1));
    boundary  = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    idx_nx    = idx + IDX_W'(1);
    snap_nx   = boundary ? value : snap;
    phase_nx  = phase;
    frames_nx = frames;
    if (boundary) begin
      if (frames == FW'(BLINK_FRAMES - 1)) begin
        frames_nx = '0;
        phase_nx  = ~phase;
      end else begin
        frames_nx = frames + FW'(1);
      end
    end
    nibble   = snap_nx[{idx_nx, 2'b00} +: NIB_W];
    lz_off   = blank_lz && (idx_nx != '0) && ((snap_nx >> {idx_nx, 2'b00}) == '0);
    suppress = lz_off || (blink_en && phase_nx);
    disp_nx  = DISP_OFF;
    if (!suppress) begin
      disp_nx.an  = ~(NUM_DIGITS'(1) << idx_nx);
      disp_nx.seg = seg_dec;
      disp_nx.dp  = ~dp_in[idx_nx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      idx         <= IDX_W'(NUM_DIGITS - 1);
      snap        <= '0;
      phase       <= 1'b0;
      frames      <= '0;
      disp_q      <= DISP_OFF;
      frame_start <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + PW'(1);
      frame_start <= boundary;
      if (tick) begin
        idx    <= idx_nx;
        snap   <= snap_nx;
        phase  <= phase_nx;
        frames <= frames_nx;
        disp_q <= disp_nx;
      end
    end
  end

  assign an  = disp_q.an;
  assign seg = disp_q.seg;
  assign dp  = disp_q.dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a slot-level display model.
module tb_seg7_scan_driver;

  localparam int unsigned DT = 4;
  localparam int unsigned BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGIT_TICKS(DT), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: slots since reset, frames since reset, snapshot taken at each frame's first slot
  int          m_edges = 0;
  int          m_idx   = 3;
  int          m_frame = 0;
  logic [15:0] m_snap  = 16'h0000;
  logic [3:0]  e_an  = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp  = 1'b1;
  logic        e_fs  = 1'b0;

  logic [6:0] hex_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic model_reset();
    m_edges = 0; m_idx = 3; m_frame = 0; m_snap = 16'h0000;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
  endtask

  task automatic model_tick();
    bit all_zero;
    bit off;
    int nib;
    m_idx = (m_idx + 1) % 4;
    e_fs  = (m_idx == 0);
    if (m_idx == 0) begin
      m_frame++;
      m_snap = value;
    end
    all_zero = 1'b1;
    for (int k = m_idx; k < 4; k++)
      if (((int'(m_snap) / (1 << (4 * k))) % 16) != 0) all_zero = 1'b0;
    off = (blank_lz && m_idx != 0 && all_zero) || (blink_en && ((m_frame / BF) % 2 == 1));
    nib = (int'(m_snap) / (1 << (4 * m_idx))) % 16;
    if (off) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = 4'hF;
      e_an[m_idx] = 1'b0;
      e_seg = hex_tbl[nib];
      e_dp  = ~dp_in[m_idx];
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    m_edges++;
    if (m_edges == DT) begin
      m_edges = 0;
      model_tick();
    end
    #1;
  endtask

  task automatic step_tick();
    do edge1(); while (m_edges != 0);
  endtask

  task automatic align_frame();
    while (m_edges != 0) edge1();
    while (m_idx != 3) step_tick();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_idle: an=%b seg=%h dp=%b fs=%b, expected 1111/7f/1/0", an, seg, dp, frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    value = 16'h1234;
    for (int i = 0; i < DT - 1; i++) begin
      edge1();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL pre_tick_idle c%0d: an=%b seg=%h dp=%b fs=%b, expected 1111/7f/1/0", i, an, seg, dp, frame_start);
      end
    end
  endtask

  task automatic test_first_frame();
    logic [6:0] s_exp [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] a_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      step_tick();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs} ||
          an !== a_exp[i] || seg !== s_exp[i] || frame_start !== (i == 0)) begin
        n_bad++;
        $display("FAIL first_frame d%0d: an=%b seg=%h fs=%b, expected an=%b seg=%h fs=%b",
                 i, an, seg, frame_start, a_exp[i], s_exp[i], i == 0);
      end
    end
  endtask

  task automatic test_tearing();
    for (int i = 0; i < 8; i++) begin
      step_tick();
      if (i == 1) value = 16'hFFFF;
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs} ||
          (i == 2 && seg !== 7'h24) || (i == 3 && seg !== 7'h79) || (i >= 4 && seg !== 7'h0E)) begin
        n_bad++;
        $display("FAIL tearing s%0d: an=%b seg=%h dp=%b fs=%b, expected an=%b seg=%h dp=%b fs=%b",
                 i, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] s42 [4] = '{7'h24, 7'h19, 7'h7F, 7'h7F};
    align_frame();
    blank_lz = 1'b1;
    value = 16'h0042;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) value = 16'h0000;
      if (i == 8) blank_lz = 1'b0;
      step_tick();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs} ||
          (i < 4 && seg !== s42[i]) || (i < 4 && i >= 2 && an !== 4'hF) ||
          (i >= 4 && i < 8 && seg !== ((i == 4) ? 7'h40 : 7'h7F)) ||
          (i >= 8 && seg !== 7'h40)) begin
        n_bad++;
        $display("FAIL blanking s%0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_dp();
    align_frame();
    blank_lz = 1'b0;
    value = 16'($urandom);
    dp_in = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        blank_lz = 1'b1;
        value = 16'h0042;
      end
      step_tick();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs} ||
          (i < 4 && dp !== (an == 4'b1011 ? 1'b0 : 1'b1)) || (i >= 4 && dp !== 1'b1)) begin
        n_bad++;
        $display("FAIL decimal_point s%0d: an=%b dp=%b, expected an=%b dp=%b", i, an, dp, e_an, e_dp);
      end
    end
    dp_in = 4'h0;
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    int lit;
    align_frame();
    value = 16'($urandom) | 16'h1000;
    blink_en = 1'b1;
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      step_tick();
      if (m_idx == 0 && an !== 4'hF) lit++;
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        n_bad++;
        $display("FAIL blink_on s%0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    n_cmp++;
    if (lit !== 4) begin
      n_bad++;
      $display("FAIL blink_duty: lit frames=%0d of 8, expected 4", lit);
    end
    blink_en = 1'b0;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      step_tick();
      if (an !== 4'hF) lit++;
    end
    n_cmp++;
    if (lit !== 16) begin
      n_bad++;
      $display("FAIL blink_off: lit slots=%0d of 16, expected 16", lit);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      edge1();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, 1'b0}) begin
        n_bad++;
        $display("FAIL hold t%0d: an=%b seg=%h dp=%b fs=%b, expected an=%b seg=%h dp=%b fs=0",
                 t, an, seg, dp, frame_start, e_an, e_seg, e_dp);
      end
      value    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      blink_en = 1'($urandom);
      step_tick();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        n_bad++;
        $display("FAIL random t%0d: an=%b seg=%h dp=%b fs=%b, expected an=%b seg=%h dp=%b fs=%b",
                 t, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
      end
    end
    blink_en = 1'b0;
    blank_lz = 1'b0;
    dp_in = 4'h0;
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    align_frame();
    value = 16'h5678;
    repeat (3) step_tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset_idle: an=%b seg=%h dp=%b fs=%b, expected 1111/7f/1/0", an, seg, dp, frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    v = 16'($urandom) | 16'h8000;
    value = v;
    for (int i = 0; i < DT - 1; i++) begin
      edge1();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL post_reset_idle c%0d: an=%b seg=%h fs=%b, expected 1111/7f/0", i, an, seg, frame_start);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step_tick();
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs} ||
          (i == 0 && (frame_start !== 1'b1 || seg !== hex_tbl[v[3:0]]))) begin
        n_bad++;
        $display("FAIL post_reset_frame d%0d: an=%b seg=%h fs=%b, expected an=%b seg=%h fs=%b",
                 i, an, seg, frame_start, e_an, e_seg, e_fs);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_tearing();
    test_blanking();
    test_dp();
    test_blink();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
